// File: rtl/cx_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cx_rom_arbiter_if
// Description : Bus bundle between the multicard bus logic and the $C800
//               expansion-ROM arbiter: address/strobe, soft switches, per-card
//               read requests and data, ROM enables and merged read path.
// Revision    : 1.0 - initial release
// ============================================================================
interface cx_rom_arbiter_if #(
  parameter int NUM_SLOTS = 8
);
  logic                     addr_strobe_i;
  logic [15:0]              addr_i;
  logic                     intcxrom_i;
  logic                     slotc3rom_i;
  logic [NUM_SLOTS-1:0]     card_rd_en_i;
  logic [8*NUM_SLOTS-1:0]   card_data_i;
  logic                     conflict_clr_i;
  logic [NUM_SLOTS-1:0]     rom_en_o;
  logic [2:0]               owner_o;
  logic                     owner_valid_o;
  logic [7:0]               data_o;
  logic                     rd_en_o;
  logic                     conflict_o;

  // Arbiter side
  modport slave (
    input  addr_strobe_i, addr_i, intcxrom_i, slotc3rom_i,
    input  card_rd_en_i, card_data_i, conflict_clr_i,
    output rom_en_o, owner_o, owner_valid_o, data_o, rd_en_o, conflict_o
  );

  // Bus / card side
  modport master (
    output addr_strobe_i, addr_i, intcxrom_i, slotc3rom_i,
    output card_rd_en_i, card_data_i, conflict_clr_i,
    input  rom_en_o, owner_o, owner_valid_o, data_o, rd_en_o, conflict_o
  );
endinterface
`default_nettype wire

// File: rtl/cx_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cx_rom_arbiter
// Description : Tracks which slot owns the shared $C800-$CFFF expansion-ROM
//               window, drives a one-hot ROM enable, and merges the cards'
//               read data with sticky multi-driver conflict detection.
// Revision    : 1.0 - initial release
// ============================================================================
module cx_rom_arbiter #(
  parameter int                   NUM_SLOTS   = 8,
  parameter logic [NUM_SLOTS-1:0] SLOT_HAS_C8 = 8'hFF
) (
  input  wire              clk_logic,
  input  wire              system_reset_n,
  cx_rom_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  // Mask widened to the 3-bit slot-number space decoded from the address
  localparam logic [7:0] c_has_c8 = 8'(SLOT_HAS_C8);

  state_t               state_q, state_d;
  logic [2:0]           owner_q, owner_d;
  logic                 conflict_q, conflict_d;

  logic [2:0]           w_slot;
  logic                 w_io_sel;
  logic                 w_c8_window;
  logic                 w_multi;
  logic [NUM_SLOTS-1:0] w_rom_en;
  logic [7:0]           w_data;

  assign w_slot      = bus.addr_i[10:8];
  // $C100-$C7FF: one slot's I/O-select page ($C0xx is not a slot page)
  assign w_io_sel    = (bus.addr_i[15:11] == 5'b11000) && (w_slot != 3'd0);
  assign w_c8_window = (bus.addr_i[15:11] == 5'b11001);
  // Two or more requesters: clearing the lowest set bit leaves something
  assign w_multi     = |(bus.card_rd_en_i & (bus.card_rd_en_i - 1'b1));

  // State, owner and sticky conflict registers
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 3'd0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      conflict_q <= conflict_d;
    end
  end

  // Ownership transitions; only bus-strobed accesses with the slot ROMs mapped in act
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (bus.addr_strobe_i && !bus.intcxrom_i) begin
      if (bus.addr_i == 16'hCFFF) begin
        state_d = ST_IDLE;
      end else if ((bus.addr_i[15:8] == 8'hC3) && !bus.slotc3rom_i) begin
        // Internal 80-column firmware claims the window
        state_d = ST_IDLE;
      end else if (w_io_sel && c_has_c8[w_slot]) begin
        state_d = ST_OWNED;
        owner_d = w_slot;
      end
    end
  end

  // Sticky conflict: a new collision overrides a simultaneous clear
  always_comb begin
    conflict_d = conflict_q;
    if (bus.conflict_clr_i) conflict_d = 1'b0;
    if (w_multi)            conflict_d = 1'b1;
  end

  // One-hot ROM enable from registered owner and the live address
  always_comb begin
    w_rom_en = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      w_rom_en[k] = (state_q == ST_OWNED) && (owner_q == 3'(k)) &&
                    !bus.intcxrom_i && w_c8_window;
    end
  end

  // Read merge: lowest-index requester wins, idle bus reads as $FF
  always_comb begin
    w_data = 8'hFF;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (bus.card_rd_en_i[k]) w_data = bus.card_data_i[8*k +: 8];
    end
  end

  assign bus.rom_en_o      = w_rom_en;
  assign bus.owner_o       = owner_q;
  assign bus.owner_valid_o = (state_q == ST_OWNED);
  assign bus.data_o        = w_data;
  assign bus.rd_en_o       = |bus.card_rd_en_i;
  assign bus.conflict_o    = conflict_q;

endmodule
`default_nettype wire
